// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for the two regfile write sources: A (execute) and B (memory).
// Handshake: a request transfers on a cycle where valid and ready are both high; the
// requester keeps reg/data stable until then, and dropping valid early withdraws it.
interface regfile_wb_arbiter_if #(
  parameter int DW = 64
);
  logic          a_valid;
  logic          a_ready;
  logic [4:0]    a_reg;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [4:0]    b_reg;
  logic [DW-1:0] b_data;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: grants A/B writebacks, orders same-register
// collisions (B first), drops writes to the zero register and flags read hazards.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int DW   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb,
  input  logic [4:0]           ReadRegister1,
  input  logic [4:0]           ReadRegister2,
  output logic                 stall1,
  output logic                 stall2,
  output logic [4:0]           WriteRegister,
  output logic [DW-1:0]        WriteData,
  output logic                 RegWrite
);
  localparam logic [4:0] ZERO_REG = 5'(NREG - 1);

  logic          out_vld;
  logic [4:0]    out_reg;
  logic [DW-1:0] out_data;
  logic          last_grant;  // 0 = A, 1 = B
  logic          grant_a;
  logic          grant_b;
  logic [4:0]    sel_reg;
  logic [DW-1:0] sel_data;
  logic          a_pend;
  logic          b_pend;

  // B wins a same-register collision because it carries the older instruction;
  // otherwise contention goes to whichever requester was not granted last.
  always_comb begin
    grant_b = 1'b0;
    grant_a = 1'b0;
    if (!reset) begin
      grant_b = wb.b_valid &&
                (!wb.a_valid || (wb.a_reg == wb.b_reg) || !last_grant);
      grant_a = wb.a_valid && !grant_b;
    end
  end

  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;

  assign sel_reg  = grant_b ? wb.b_reg  : wb.a_reg;
  assign sel_data = grant_b ? wb.b_data : wb.a_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld    <= 1'b0;
      out_reg    <= '0;
      out_data   <= '0;
      last_grant <= 1'b1;
    end else if (grant_a || grant_b) begin
      out_vld    <= (sel_reg != ZERO_REG);
      out_reg    <= sel_reg;
      out_data   <= sel_data;
      last_grant <= grant_b;
    end else begin
      out_vld <= 1'b0;
    end
  end

  assign RegWrite      = out_vld;
  assign WriteRegister = out_reg;
  assign WriteData     = out_data;

  // A write is in flight if it sits in the output stage or is still waiting for a grant.
  assign a_pend = wb.a_valid && !wb.a_ready;
  assign b_pend = wb.b_valid && !wb.b_ready;

  always_comb begin
    stall1 = (ReadRegister1 != ZERO_REG) &&
             ((out_vld && (out_reg == ReadRegister1)) ||
              (a_pend && (wb.a_reg == ReadRegister1)) ||
              (b_pend && (wb.b_reg == ReadRegister1)));
    stall2 = (ReadRegister2 != ZERO_REG) &&
             ((out_vld && (out_reg == ReadRegister2)) ||
              (a_pend && (wb.a_reg == ReadRegister2)) ||
              (b_pend && (wb.b_reg == ReadRegister2)));
  end
endmodule
